rr_chan_mux: RTL and testbench
==============================

Name: rr_chan_mux

Overview:
- Parametrised N:1 channel multiplexer; next generation of the team's 4:1 decoder-based mux.
- Adds per-channel valid/ready handshakes, a registered output stage, and two selection modes:
  - fixed select through a one-hot decoder;
  - fair round-robin arbitration.
- Sits between several producer channels and a single downstream consumer.

Parameters:
- WIDTH, 4: data width per channel in bits.
- SEL_W, 2: select/channel-index width. CHANNELS = 2**SEL_W, derived via localparam and not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready, combinational, at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. In-flight word discarded. in_ready all 0 while rst_n low.
- load = !out_valid || out_ready. The output register may accept a new word only when load=1.
- Fixed mode (mode=0):
  - dec = one-hot decode of sel.
  - grant = dec & in_valid.
  - Other channels' valids are ignored.
- Round-robin mode (mode=1):
  - Search from ptr upward, wrapping modulo CHANNELS.
  - First channel with in_valid=1 wins; grant is one-hot on the winner.
- in_ready[i] = load && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a clock edge with load=1:
  - If grant is non-zero: out_data <= winner data, out_chan <= winner index, out_valid <= 1.
  - If grant is zero: out_valid <= 0; out_data and out_chan hold their values.
- On a clock edge with load=0: all output registers hold. Inputs must keep their data stable under valid (standard handshake).
- Pointer update:
  - Only in mode=1 and only on a transfer: ptr <= (winner+1) mod CHANNELS, with wrap from CHANNELS-1 to 0.
  - In mode=0, ptr holds.
- Latency and throughput: 1 cycle input transfer to out_valid. Full throughput of 1 word/cycle while out_ready=1.
- Back-pressure: out_valid=1 && out_ready=0 → all in_ready=0; out_data is stable until accepted.
- Simultaneous accept and refill: out_ready=1 with a granted input loads the new word in the same edge, with no bubble.
- Mode or sel change: takes effect combinationally on grant. It never alters a word already in the output register.
- No valid inputs in round-robin mode: ptr holds, out_valid drops after the current word is accepted.

Optional Feature:
- Macro: RR_CHAN_MUX_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - In mode=1, while lock=1 and the last winner (ptr-1 mod CHANNELS) has in_valid=1, that channel keeps the grant and ptr does not advance. This is a burst lock.
  - If the locked channel drops valid, normal search from ptr resumes.
  - lock has no effect in mode=0.
- Not defined: no lock port; ptr advances after every round-robin transfer.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0 immediately (asynchronous); after release, first round-robin grant starts at channel 0.
- Fixed mode, out_ready=1: mode=0, in_data = {ch3=4'h6, ch2=4'h3, ch1=4'hA, ch0=4'hC}, all valid, sel stepped 0,1,2,3 one per cycle → out_data C,A,3,6 with out_chan 0,1,2,3, each 1 cycle after its sel; in_ready one-hot matching sel.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1 with no idle cycles.
- Round-robin skip and wrap: mode=1, only ch1 and ch3 valid, ptr=2 → order 3,1,3,1; ch0 and ch2 in_ready never asserted.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 (data 4'hF) → out_data stays F, all in_ready=0, ptr unchanged; out_ready=1 → next word loads on the same edge.
- Lock (RR_CHAN_MUX_LOCK_EN): mode=1, lock=1, ch2 wins then stays valid 4 cycles with ch0 and ch3 also valid → out_chan 2,2,2,2; lock=0 → next grant is ch3.

Source files
------------

// File: rtl/rr_chan_mux.sv
// rr_chan_mux: N:1 channel multiplexer with per-channel valid/ready,
// a registered output stage, and fixed-select or round-robin selection.
//
// Optional feature: define RR_CHAN_MUX_LOCK_EN to add the 'lock' input.
// While lock=1 in round-robin mode, the last winner keeps the grant for as
// long as it stays valid.
//
// Handshake: a word moves on any edge where valid && ready are both high.
// The producer holds data stable while valid is high. in_ready is
// combinational and at most one bit is high. out_data and out_chan hold
// while out_valid && !out_ready.
module rr_chan_mux #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mode,
  input  logic [SEL_W-1:0]                  sel,
  input  logic [(2**SEL_W)*WIDTH-1:0]       in_data,
  input  logic [(2**SEL_W)-1:0]             in_valid,
  output logic [(2**SEL_W)-1:0]             in_ready,
`ifdef RR_CHAN_MUX_LOCK_EN
  input  logic                              lock,
`endif
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SEL_W-1:0]                  out_chan
);

  localparam int CHANNELS = 2**SEL_W;

  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_out_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_hold;
  logic                w_found;
  logic [SEL_W-1:0]    w_idx;
  logic [CHANNELS-1:0] w_grant;
  logic [WIDTH-1:0]    w_win_data;

  // The output register can take a word when it is empty or being drained.
  assign w_load = !r_out_valid || out_ready;

  // Round-robin search: the first valid channel at or above ptr, wrapping.
  always_comb begin
    logic [SEL_W-1:0] cand;
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    cand       = r_ptr;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = r_ptr + SEL_W'(k);
      if (!w_rr_found && in_valid[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand;
      end
    end
  end

  // Select the winner. Fixed mode considers only sel's valid. Round-robin
  // mode can let the burst lock override the search result.
  always_comb begin
    w_hold  = 1'b0;
    w_found = 1'b0;
    w_idx   = '0;
    if (!mode) begin
      w_found = in_valid[sel];
      w_idx   = sel;
    end else begin
      w_found = w_rr_found;
      w_idx   = w_rr_idx;
`ifdef RR_CHAN_MUX_LOCK_EN
      if (lock && in_valid[r_ptr - 1'b1]) begin
        w_hold  = 1'b1;
        w_found = 1'b1;
        w_idx   = r_ptr - 1'b1;
      end
`endif
    end
  end

  // One-hot grant for the winner. Outputs are gated so every ready is low
  // while reset is asserted.
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_idx] = 1'b1;
    in_ready = (w_load && rst_n) ? w_grant : '0;
  end

  assign w_win_data = in_data[w_idx*WIDTH +: WIDTH];

  // Output stage: load the winner, drop valid when nothing is granted, and
  // hold everything under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_data  <= w_win_data;
        r_out_chan  <= w_idx;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: advances past the winner only on a round-robin
  // transfer. A locked burst keeps the pointer where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (mode && w_load && w_found && !w_hold) begin
      r_ptr <= w_idx + 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

  // The hold flag is only produced when the lock feature is built in.
  logic w_unused;
  assign w_unused = w_hold;

endmodule

// File: tb/tb_rr_chan_mux.sv
// Directed testbench for rr_chan_mux (WIDTH=4, SEL_W=2).
// The lock section runs only when RR_CHAN_MUX_LOCK_EN is defined.
module tb_rr_chan_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
`ifdef RR_CHAN_MUX_LOCK_EN
  logic        lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rr_chan_mux #(.WIDTH(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_CHAN_MUX_LOCK_EN
    .lock      (lock),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered output triple.
  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_chan"},  32'(out_chan),  32'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 16'h63AC;
    in_valid  = 4'hF;
    out_ready = 1'b1;
`ifdef RR_CHAN_MUX_LOCK_EN
    lock      = 1'b0;
`endif
    #3;
    chk_out("reset", 1'b0, 4'h0, 2'd0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed mode: sel 0..3 gives C,A,3,6.
    #1;
    chk("fix_rdy0", 32'(in_ready), 32'b0001);
    tick(); chk_out("fix0", 1'b1, 4'hC, 2'd0);
    sel = 2'd1; #1;
    chk("fix_rdy1", 32'(in_ready), 32'b0010);
    tick(); chk_out("fix1", 1'b1, 4'hA, 2'd1);
    sel = 2'd2; #1;
    chk("fix_rdy2", 32'(in_ready), 32'b0100);
    tick(); chk_out("fix2", 1'b1, 4'h3, 2'd2);
    sel = 2'd3; #1;
    chk("fix_rdy3", 32'(in_ready), 32'b1000);
    tick(); chk_out("fix3", 1'b1, 4'h6, 2'd3);

    // Round-robin fairness. ptr is still 0 because fixed mode never moves it.
    mode = 1'b1; #1;
    chk("rr_rdy_start", 32'(in_ready), 32'b0001);
    tick(); chk_out("rr0", 1'b1, 4'hC, 2'd0);
    tick(); chk_out("rr1", 1'b1, 4'hA, 2'd1);
    tick(); chk_out("rr2", 1'b1, 4'h3, 2'd2);
    tick(); chk_out("rr3", 1'b1, 4'h6, 2'd3);
    tick(); chk_out("rr4", 1'b1, 4'hC, 2'd0);
    tick(); chk_out("rr5", 1'b1, 4'hA, 2'd1);

    // Skip and wrap. ptr is 2 and only ch1/ch3 are valid, so the order is 3,1,3,1.
    in_valid = 4'b1010; #1;
    chk("sk_rdy0", 32'(in_ready), 32'b1000);
    tick(); chk_out("sk0", 1'b1, 4'h6, 2'd3);
    chk("sk_rdy1", 32'(in_ready), 32'b0010);
    tick(); chk_out("sk1", 1'b1, 4'hA, 2'd1);
    chk("sk_rdy2", 32'(in_ready), 32'b1000);
    tick(); chk_out("sk2", 1'b1, 4'h6, 2'd3);
    chk("sk_rdy3", 32'(in_ready), 32'b0010);
    tick(); chk_out("sk3", 1'b1, 4'hA, 2'd1);

    // Back-pressure. ptr is 2, so ch2 loads F and ptr becomes 3.
    in_valid = 4'b0100;
    in_data  = 16'h0F00;
    tick(); chk_out("bp_load", 1'b1, 4'hF, 2'd2);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data   = 16'h5F21;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(in_ready), 32'h0);
      tick(); chk_out("bp_hold", 1'b1, 4'hF, 2'd2);
    end
    // Accept and refill on the same edge. The grant to ch3 shows ptr stayed 3.
    out_ready = 1'b1; #1;
    chk("bp_rdy_rel", 32'(in_ready), 32'b1000);
    tick(); chk_out("bp_refill", 1'b1, 4'h5, 2'd3);

    // No valid inputs: out_valid drops, data and chan hold.
    in_valid = 4'h0; #1;
    chk("idle_rdy", 32'(in_ready), 32'h0);
    tick(); chk_out("idle", 1'b0, 4'h5, 2'd3);

    // Asynchronous reset mid-stream. ptr was 0 after ch3 and becomes 1 after ch0.
    in_valid = 4'hF;
    tick(); chk_out("pre_rst", 1'b1, 4'h1, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'h0, 2'd0);
    chk("async_rst_rdy", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("post_rst_rdy", 32'(in_ready), 32'b0001);
    tick(); chk_out("post_rst", 1'b1, 4'h1, 2'd0);

`ifdef RR_CHAN_MUX_LOCK_EN
    // Burst lock. ptr is 1 and ch0 is idle, so ch2 wins first and then holds.
    lock     = 1'b1;
    in_valid = 4'b0100;
    tick(); chk_out("lk0", 1'b1, 4'hF, 2'd2);
    in_valid = 4'b1101;
    tick(); chk_out("lk1", 1'b1, 4'hF, 2'd2);
    tick(); chk_out("lk2", 1'b1, 4'hF, 2'd2);
    tick(); chk_out("lk3", 1'b1, 4'hF, 2'd2);
    lock = 1'b0;
    tick(); chk_out("lk_rel", 1'b1, 4'h5, 2'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
